// File: rtl/lsu.sv
// Load/store unit: one aligned data-memory transaction per request; accept-to-done 3 cycles minimum,
// 1 cycle for misaligned/illegal. Holds the request on the bus until grant; waits indefinitely for rvalid.
module lsu #(
  parameter int XLEN   = 64,
  parameter int DATA_W = 64,
  parameter int STRB_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_funct3_i,
  input  logic [XLEN-1:0]   lsu_addr_i,
  input  logic [XLEN-1:0]   lsu_wdata_i,
  output logic              lsu_busy_o,
  output logic              lsu_done_o,
  output logic [XLEN-1:0]   lsu_rdata_o,
  output logic              lsu_misalign_o,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [STRB_W-1:0] mem_wstrb_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              misalign_q, misalign_d;

  logic              aligned_in;
  logic [2:0]        off;
  logic [STRB_W-1:0] strb;
  logic [DATA_W-1:0] lane;
  logic [XLEN-1:0]   ext;
  logic              in_req;

  assign off = addr_q[2:0];

  // funct3 111 is treated exactly like a misaligned access
  always_comb begin
    aligned_in = 1'b0;
    case (lsu_funct3_i)
      3'b000, 3'b100: aligned_in = 1'b1;
      3'b001, 3'b101: aligned_in = ~lsu_addr_i[0];
      3'b010, 3'b110: aligned_in = (lsu_addr_i[1:0] == 2'b00);
      3'b011:         aligned_in = (lsu_addr_i[2:0] == 3'b000);
      default:        aligned_in = 1'b0;
    endcase
  end

  always_comb begin
    strb = '0;
    case (funct3_q[1:0])
      2'b00:   strb = STRB_W'(8'h01) << off;
      2'b01:   strb = STRB_W'(8'h03) << off;
      2'b10:   strb = STRB_W'(8'h0F) << off;
      default: strb = '1;
    endcase
  end

  always_comb begin
    lane = mem_rdata_i >> {off, 3'b000};
    ext  = lane;
    case (funct3_q)
      3'b000:  ext = {{(XLEN-8){lane[7]}},   lane[7:0]};
      3'b001:  ext = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b010:  ext = {{(XLEN-32){lane[31]}}, lane[31:0]};
      3'b100:  ext = {{(XLEN-8){1'b0}},      lane[7:0]};
      3'b101:  ext = {{(XLEN-16){1'b0}},     lane[15:0]};
      3'b110:  ext = {{(XLEN-32){1'b0}},     lane[31:0]};
      default: ext = lane;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE: if (lsu_req_i) begin
        we_d       = lsu_we_i;
        funct3_d   = lsu_funct3_i;
        addr_d     = lsu_addr_i;
        wdata_d    = lsu_wdata_i;
        rdata_d    = '0;
        misalign_d = ~aligned_in;
        state_d    = aligned_in ? REQ : DONE;
      end
      REQ:  if (mem_gnt_i) state_d = WAIT;
      WAIT: if (mem_rvalid_i) begin
        rdata_d = we_q ? '0 : ext;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  assign in_req         = (state_q == REQ);
  assign lsu_busy_o     = (state_q != IDLE);
  assign lsu_done_o     = (state_q == DONE);
  assign lsu_rdata_o    = lsu_done_o ? rdata_q : '0;
  assign lsu_misalign_o = lsu_done_o & misalign_q;
  assign mem_req_o      = in_req;
  assign mem_we_o       = in_req & we_q;
  assign mem_addr_o     = in_req ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign mem_wstrb_o    = (in_req && we_q) ? strb : '0;
  assign mem_wdata_o    = (in_req && we_q) ? (wdata_q << {off, 3'b000}) : '0;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a small bus responder with programmable grant/rvalid stalls, per-scenario checks.
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_req_i, lsu_we_i;
  logic [2:0]  lsu_funct3_i;
  logic [63:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_busy_o, lsu_done_o, lsu_misalign_o;
  logic [63:0] lsu_rdata_o;
  logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
  logic [63:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [7:0]  mem_wstrb_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // results recorded by do_txn
  int          lat, nreq;
  logic [63:0] rd, s_addr, s_wdata;
  logic [7:0]  s_strb;
  logic        mis, s_we, stable;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu #(.XLEN(64), .DATA_W(64), .STRB_W(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_funct3_i(lsu_funct3_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_busy_o(lsu_busy_o), .lsu_done_o(lsu_done_o), .lsu_rdata_o(lsu_rdata_o),
    .lsu_misalign_o(lsu_misalign_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wstrb_o(mem_wstrb_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  // Issues one request and plays the bus: grant after gstall REQ cycles, rvalid rstall cycles after WAIT entry.
  // spur drives a bogus rvalid with 0x8000_0000 during ungranted REQ cycles.
  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] rdat,
                        input int gstall, input int rstall, input bit spur);
    int gcnt, rcnt, t0;
    bit granted, answered, seen;
    @(negedge clk);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_funct3_i = f3; lsu_addr_i = addr; lsu_wdata_i = wdata;
    t0 = cyc; lat = -1; nreq = 0; gcnt = 0; rcnt = 0;
    granted = 0; answered = 0; seen = 0; stable = 1'b1;
    rd = '0; mis = 1'b0; s_addr = '0; s_wdata = '0; s_strb = '0; s_we = 1'b0;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      if (lsu_done_o) begin
        lat = cyc - t0; rd = lsu_rdata_o; mis = lsu_misalign_o;
      end else if (granted) begin
        if (!answered) begin
          if (rcnt == rstall) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = rdat; answered = 1;
          end
          rcnt++;
        end
      end else if (mem_req_o) begin
        nreq++;
        if (!seen) begin
          s_addr = mem_addr_o; s_wdata = mem_wdata_o; s_strb = mem_wstrb_o; s_we = mem_we_o; seen = 1;
        end else if (mem_addr_o !== s_addr || mem_wdata_o !== s_wdata ||
                     mem_wstrb_o !== s_strb || mem_we_o !== s_we) begin
          stable = 1'b0;
        end
        if (gcnt == gstall) begin
          mem_gnt_i = 1'b1; granted = 1;
        end else if (spur) begin
          mem_rvalid_i = 1'b1; mem_rdata_i = 64'h0000_0000_8000_0000;
        end
        gcnt++;
      end
    end
    lsu_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_funct3_i = '0; lsu_addr_i = '0; lsu_wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    #2;
    checks++; if (lsu_busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", lsu_busy_o); end
    checks++; if (lsu_done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", lsu_done_o); end
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", mem_req_o); end
    checks++; if ({mem_addr_o, mem_wdata_o, lsu_rdata_o} !== '0) begin failures++; $display("FAIL reset_buses got=%h/%h/%h want=0", mem_addr_o, mem_wdata_o, lsu_rdata_o); end
    checks++; if ({mem_wstrb_o, mem_we_o, lsu_misalign_o} !== '0) begin failures++; $display("FAIL reset_ctl got=%h want=0", {mem_wstrb_o, mem_we_o, lsu_misalign_o}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lb_sign();
    do_txn(1'b0, 3'b000, 64'h1003, '0, 64'h0000_0000_8100_0000, 1, 0, 1);
    checks++; if (lat !== 4) begin failures++; $display("FAIL lb_latency got=%0d want=4", lat); end
    checks++; if (rd !== 64'hFFFF_FFFF_FFFF_FF81) begin failures++; $display("FAIL lb_rdata got=%h want=ffffffffffffff81", rd); end
    checks++; if (s_addr !== 64'h1000) begin failures++; $display("FAIL lb_addr got=%h want=1000", s_addr); end
  endtask

  task automatic test_lhu();
    do_txn(1'b0, 3'b101, 64'h2006, 64'hFFFF_FFFF_FFFF_FFFF, 64'hBEEF_0000_0000_0000, 0, 0, 0);
    checks++; if (s_strb !== 8'h00 || s_we !== 1'b0) begin failures++; $display("FAIL lhu_strb got=%h we=%b want=00 we=0", s_strb, s_we); end
    checks++; if (rd !== 64'h0000_0000_0000_BEEF) begin failures++; $display("FAIL lhu_rdata got=%h want=000000000000beef", rd); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL lhu_latency got=%0d want=3", lat); end
  endtask

  task automatic test_sw();
    do_txn(1'b1, 3'b010, 64'h3004, 64'h0000_0000_1234_5678, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0, 0);
    checks++; if (s_addr !== 64'h3000) begin failures++; $display("FAIL sw_addr got=%h want=3000", s_addr); end
    checks++; if (s_strb !== 8'hF0 || s_we !== 1'b1) begin failures++; $display("FAIL sw_strb got=%h we=%b want=f0 we=1", s_strb, s_we); end
    checks++; if (s_wdata[63:32] !== 32'h1234_5678) begin failures++; $display("FAIL sw_wdata got=%h want=12345678", s_wdata[63:32]); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL sw_latency got=%0d want=3", lat); end
    checks++; if (rd !== 64'h0) begin failures++; $display("FAIL sw_rdata got=%h want=0", rd); end
  endtask

  task automatic test_misalign();
    do_txn(1'b0, 3'b011, 64'h4004, '0, 64'h1111_2222_3333_4444, 0, 0, 0);
    checks++; if (lat !== 1) begin failures++; $display("FAIL ld_mis_latency got=%0d want=1", lat); end
    checks++; if (mis !== 1'b1) begin failures++; $display("FAIL ld_mis_flag got=%b want=1", mis); end
    checks++; if (nreq !== 0) begin failures++; $display("FAIL ld_mis_busreq got=%0d want=0", nreq); end
    checks++; if (rd !== 64'h0) begin failures++; $display("FAIL ld_mis_rdata got=%h want=0", rd); end
    do_txn(1'b1, 3'b001, 64'h2001, 64'hFFFF, '0, 0, 0, 0);
    checks++; if (lat !== 1 || mis !== 1'b1 || nreq !== 0) begin failures++; $display("FAIL sh_mis got lat=%0d mis=%b req=%0d want 1/1/0", lat, mis, nreq); end
    do_txn(1'b0, 3'b111, 64'h2000, '0, '0, 0, 0, 0);
    checks++; if (lat !== 1 || mis !== 1'b1 || nreq !== 0) begin failures++; $display("FAIL illegal_f3 got lat=%0d mis=%b req=%0d want 1/1/0", lat, mis, nreq); end
  endtask

  task automatic test_sd_stall();
    do_txn(1'b1, 3'b011, 64'h8000, 64'h0123_4567_89AB_CDEF, '0, 4, 1, 0);
    checks++; if (lat !== 8) begin failures++; $display("FAIL sd_latency got=%0d want=8", lat); end
    checks++; if (stable !== 1'b1) begin failures++; $display("FAIL sd_stable got=%b want=1", stable); end
    checks++; if (nreq !== 5) begin failures++; $display("FAIL sd_req_cycles got=%0d want=5", nreq); end
    checks++; if (s_strb !== 8'hFF || s_wdata !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL sd_bus got strb=%h wdata=%h want ff/0123456789abcdef", s_strb, s_wdata); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (lsu_done_o !== 1'b0) begin failures++; $display("FAIL sd_single_done cyc%0d got=%b want=0", i, lsu_done_o); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_funct3_i = 3'b011; lsu_addr_i = 64'h5000; lsu_wdata_i = 64'hA5A5_A5A5_A5A5_A5A5;
    @(negedge clk);
    checks++; if (mem_req_o !== 1'b1 || lsu_busy_o !== 1'b1) begin failures++; $display("FAIL rmid_req got req=%b busy=%b want 1/1", mem_req_o, lsu_busy_o); end
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    rst_n = 1'b0; lsu_req_i = 1'b0;
    #1;
    checks++; if ({lsu_busy_o, lsu_done_o, lsu_misalign_o, mem_req_o, mem_we_o, mem_wstrb_o} !== '0) begin failures++; $display("FAIL rmid_ctl got=%b want=0", {lsu_busy_o, lsu_done_o, lsu_misalign_o, mem_req_o, mem_we_o, mem_wstrb_o}); end
    checks++; if ({mem_addr_o, mem_wdata_o, lsu_rdata_o} !== '0) begin failures++; $display("FAIL rmid_buses got=%h/%h/%h want=0", mem_addr_o, mem_wdata_o, lsu_rdata_o); end
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    checks++; if (lsu_done_o !== 1'b0 || lsu_busy_o !== 1'b0) begin failures++; $display("FAIL rmid_late_rvalid got done=%b busy=%b want 0/0", lsu_done_o, lsu_busy_o); end
    do_txn(1'b0, 3'b010, 64'h6008, '0, 64'h0000_0000_8765_4321, 0, 0, 0);
    checks++; if (lat !== 3 || rd !== 64'hFFFF_FFFF_8765_4321) begin failures++; $display("FAIL rmid_next got lat=%0d rd=%h want 3/ffffffff87654321", lat, rd); end
  endtask

  task automatic test_back_to_back();
    do_txn(1'b0, 3'b100, 64'h7005, '0, 64'h0000_AB00_0000_0000, 0, 0, 0);
    checks++; if (lat !== 3 || rd !== 64'h0000_0000_0000_00AB) begin failures++; $display("FAIL b2b_lbu got lat=%0d rd=%h want 3/00000000000000ab", lat, rd); end
    do_txn(1'b0, 3'b110, 64'h7004, '0, 64'hF00D_CAFE_0000_0000, 0, 0, 0);
    checks++; if (lat !== 3 || rd !== 64'h0000_0000_F00D_CAFE) begin failures++; $display("FAIL b2b_lwu got lat=%0d rd=%h want 3/00000000f00dcafe", lat, rd); end
    @(negedge clk);
    checks++; if (lsu_rdata_o !== 64'h0 || lsu_busy_o !== 1'b0) begin failures++; $display("FAIL b2b_idle got rd=%h busy=%b want 0/0", lsu_rdata_o, lsu_busy_o); end
  endtask

  initial begin
    test_reset();
    test_lb_sign();
    test_lhu();
    test_sw();
    test_misalign();
    test_sd_stall();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
